icache_nway: RTL and testbench

Parametrised N-way set-associative instruction cache with an integrated refill controller, replacing the fixed 2-way, 2 KB storage-only instruction cache. It sits between the fetch stage and the shared memory port. Lookup is single-cycle on a hit. On a miss it stalls fetch, refills a whole block word-by-word from memory into a chosen victim way, and then completes the access.

---
 rtl/icache_pkg.sv | 27 ++
 rtl/icache_way.sv | 45 ++++
 rtl/icache_nway.sv | 158 +++++++++++++++
 tb/tb_icache_nway.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the N-way instruction cache.
// Field widths are derived from the cache parameters so every file agrees on the address split.
package icache_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } icache_state_t;

  function automatic int OFF_W(input int words);
    return $clog2(words) + 1;
  endfunction

  function automatic int IDX_W(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int TAG_W(input int addr_w, input int sets, input int words);
    return addr_w - IDX_W(sets) - OFF_W(words);
  endfunction

  function automatic int WAY_W(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: tag, valid and data arrays.
// Reads are combinational; a word-write port fills data and a tag-write port marks the line valid.
module icache_way
  import icache_pkg::*;
#(
  parameter int SETS     = 64,
  parameter int WORDS    = 8,
  parameter int TAG_BITS = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_inval_all,
  input  logic [IDX_W(SETS)-1:0]     i_rd_idx,
  input  logic [$clog2(WORDS)-1:0]   i_rd_word,
  output logic                       o_valid,
  output logic [TAG_BITS-1:0]        o_tag,
  output logic [15:0]                o_data,
  input  logic                       i_we_word,
  input  logic                       i_we_tag,
  input  logic [IDX_W(SETS)-1:0]     i_wr_idx,
  input  logic [$clog2(WORDS)-1:0]   i_wr_word,
  input  logic [15:0]                i_wr_data,
  input  logic [TAG_BITS-1:0]        i_wr_tag
);

  logic [15:0]         r_data [SETS][WORDS];
  logic [TAG_BITS-1:0] r_tag  [SETS];
  logic [SETS-1:0]     r_valid;

  // Tag and data storage are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we_word) r_data[i_wr_idx][i_wr_word] <= i_wr_data;
    if (i_we_tag)  r_tag[i_wr_idx] <= i_wr_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst || i_inval_all) r_valid <= '0;
    else if (i_we_tag)       r_valid[i_wr_idx] <= 1'b1;
  end

  assign o_valid = r_valid[i_rd_idx];
  assign o_tag   = r_tag[i_rd_idx];
  assign o_data  = r_data[i_rd_idx][i_rd_word];

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with a block refill controller.
// Hits return data combinationally; misses stall fetch while a whole block is read into a victim way.
module icache_nway
  import icache_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int SETS   = 64,
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [15:0]       cpu_data,
  output logic              cpu_stall,
  input  logic              flush,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [15:0]       mem_data,
  output icache_state_t     o_dbg_state
);

  localparam int OW = OFF_W(WORDS);
  localparam int IW = IDX_W(SETS);
  localparam int TW = TAG_W(ADDR_W, SETS, WORDS);
  localparam int WW = WAY_W(WAYS);
  localparam int BW = OW - 1;

  icache_state_t r_state, w_next;
  logic [WW-1:0] r_rr [SETS];
  logic [WW-1:0] r_victim, w_victim, w_inv_way;
  logic [IW-1:0] r_idx, w_idx;
  logic [TW-1:0] r_tag, w_tag;
  logic [BW-1:0] r_beat, w_word;
  logic          r_flush_pend;

  logic [WAYS-1:0]         w_valid;
  logic [WAYS-1:0][TW-1:0] w_tags;
  logic [WAYS-1:0][15:0]   w_data;
  logic [15:0]             w_hit_data;
  logic w_hit_any, w_hit, w_inv_found, w_stall, w_inval, w_fill_beat, w_last;
  logic w_unused;

  assign w_word   = cpu_addr[OW-1:1];
  assign w_idx    = cpu_addr[OW+IW-1:OW];
  assign w_tag    = cpu_addr[ADDR_W-1:OW+IW];
  assign w_unused = cpu_addr[0];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way #(.SETS(SETS), .WORDS(WORDS), .TAG_BITS(TW)) u_way (
      .clk        (clk),
      .rst        (rst),
      .i_inval_all(w_inval),
      .i_rd_idx   (w_idx),
      .i_rd_word  (w_word),
      .o_valid    (w_valid[g]),
      .o_tag      (w_tags[g]),
      .o_data     (w_data[g]),
      .i_we_word  (w_fill_beat && (r_victim == WW'(g))),
      .i_we_tag   (w_last && (r_victim == WW'(g))),
      .i_wr_idx   (r_idx),
      .i_wr_word  (r_beat),
      .i_wr_data  (mem_data),
      .i_wr_tag   (r_tag)
    );
  end

  // Scanning from the top down lets the lowest-numbered way win both searches.
  always_comb begin
    w_hit_any   = 1'b0;
    w_hit_data  = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_valid[w] && (w_tags[w] == w_tag)) begin
        w_hit_any  = 1'b1;
        w_hit_data = w_data[w];
      end
      if (!w_valid[w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WW'(w);
      end
    end
  end

  // A flush in IDLE empties the set, so the post-flush victim is way 0.
  assign w_hit    = (r_state == S_IDLE) && !flush && w_hit_any;
  assign w_victim = flush ? '0 : (w_inv_found ? w_inv_way : r_rr[w_idx]);

  always_comb begin
    w_next      = r_state;
    w_stall     = 1'b0;
    w_inval     = 1'b0;
    w_fill_beat = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_inval = flush;
        if (cpu_req && !w_hit) begin
          w_stall = 1'b1;
          w_next  = S_FILL;
        end
      end
      S_FILL: begin
        w_stall = 1'b1;
        if (mem_valid) begin
          w_fill_beat = 1'b1;
          if (r_beat == BW'(WORDS - 1)) begin
            w_last = 1'b1;
            w_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_stall = 1'b1;
        w_inval = flush || r_flush_pend;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_beat       <= '0;
      r_flush_pend <= 1'b0;
      for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && (w_next == S_FILL)) begin
        r_victim <= w_victim;
        r_idx    <= w_idx;
        r_tag    <= w_tag;
        r_beat   <= '0;
      end else if (w_fill_beat) begin
        r_beat <= r_beat + BW'(1);
      end
      if (r_state == S_DONE)                r_flush_pend <= 1'b0;
      else if ((r_state == S_FILL) && flush) r_flush_pend <= 1'b1;
      if (w_inval) begin
        for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
      end else if (w_last) begin
        r_rr[r_idx] <= (r_rr[r_idx] == WW'(WAYS - 1)) ? '0 : r_rr[r_idx] + WW'(1);
      end
    end
  end

  // Outputs are forced to zero while reset is held.
  assign cpu_stall   = rst && w_stall;
  assign mem_rd      = rst && (r_state == S_FILL);
  assign mem_addr    = mem_rd ? {r_tag, r_idx, {OW{1'b0}}} : '0;
  assign cpu_data    = (rst && w_hit) ? w_hit_data : '0;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway: a 2-way default build and a 4-way/16-set build share the stimulus.
// Expected fetch data is queued when a request is issued and compared when the stall clears.
module tb_icache_nway;
  import icache_pkg::*;

  logic        clk, rst, cpu_req, flush, mem_valid;
  logic [15:0] cpu_addr, mem_data;
  bit          sel;

  logic          req0, req1, stall0, stall1, mem_rd0, mem_rd1;
  logic [15:0]   cpu_data0, cpu_data1, mem_addr0, mem_addr1;
  icache_state_t dbg0, dbg1;

  logic          stall_m, mem_rd_m;
  logic [15:0]   cpu_data_m, mem_addr_m;
  icache_state_t dbg_m;

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  assign req0       = cpu_req && !sel;
  assign req1       = cpu_req && sel;
  assign stall_m    = sel ? stall1 : stall0;
  assign mem_rd_m   = sel ? mem_rd1 : mem_rd0;
  assign cpu_data_m = sel ? cpu_data1 : cpu_data0;
  assign mem_addr_m = sel ? mem_addr1 : mem_addr0;
  assign dbg_m      = sel ? dbg1 : dbg0;

  icache_nway #(.WAYS(2), .SETS(64), .WORDS(8), .ADDR_W(16)) dut0 (
    .clk(clk), .rst(rst), .cpu_req(req0), .cpu_addr(cpu_addr), .cpu_data(cpu_data0),
    .cpu_stall(stall0), .flush(flush), .mem_rd(mem_rd0), .mem_addr(mem_addr0),
    .mem_valid(mem_valid), .mem_data(mem_data), .o_dbg_state(dbg0)
  );

  icache_nway #(.WAYS(4), .SETS(16), .WORDS(8), .ADDR_W(16)) dut1 (
    .clk(clk), .rst(rst), .cpu_req(req1), .cpu_addr(cpu_addr), .cpu_data(cpu_data1),
    .cpu_stall(stall1), .flush(flush), .mem_rd(mem_rd1), .mem_addr(mem_addr1),
    .mem_valid(mem_valid), .mem_data(mem_data), .o_dbg_state(dbg1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one fetch and play memory until the stall clears. Memory word i of a block is seed+i.
  // fills = refills expected (0 = hit); flush_beat/rst_beat inject an event on that beat (-1 = none).
  task automatic access(input string tag, input logic [15:0] addr, input logic [15:0] seed,
                        input int fills, input int gap, input int flush_beat,
                        input bit flush_now, input int rst_beat);
    int n_stall, beat, fc;
    bit got, prev_rd, flushed, aborted;
    logic [15:0] exp;
    exp_q.push_back(seed + 16'(addr[3:1]));
    cpu_req = 1'b1;
    cpu_addr = addr;
    flush = flush_now;
    n_stall = 0; beat = 0; fc = 0;
    got = 0; prev_rd = 0; flushed = 0; aborted = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (cyc > 0) flush = 1'b0;
      if (!stall_m) begin
        got = 1;
        break;
      end
      n_stall++;
      if (mem_rd_m) begin
        if (!prev_rd) begin
          chk({tag, "_maddr"}, 32'(mem_addr_m), 32'(addr & 16'hFFF0));
          beat = 0;
          fc = 0;
        end
        if (beat < 8 && (fc % gap) == 0) begin
          if (beat == rst_beat && !aborted) begin
            rst = 1'b0;
            aborted = 1;
          end
          if (beat == flush_beat && !flushed) begin
            flush = 1'b1;
            flushed = 1;
          end
          mem_valid = 1'b1;
          mem_data = seed + 16'(beat);
          beat++;
        end else begin
          mem_valid = 1'b0;
        end
        fc++;
      end else begin
        mem_valid = 1'b0;
      end
      prev_rd = mem_rd_m;
      if (aborted) break;
    end
    if (aborted) begin
      void'(exp_q.pop_front());
      @(posedge clk);
      #1;
      rst = 1'b1;
      cpu_req = 1'b0;
      @(negedge clk);
      chk({tag, "_rd_after_rst"}, 32'(mem_rd_m), 32'd0);
      chk({tag, "_stall_after_rst"}, 32'(stall_m), 32'd0);
      chk({tag, "_state_after_rst"}, 32'(dbg_m), 32'(S_IDLE));
      @(posedge clk);
      #1;
      mem_data = seed + 16'd5;
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      return;
    end
    exp = exp_q.pop_front();
    chk({tag, "_done"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_stall_cycles"}, 32'(n_stall), 32'(fills * (7 * gap + 3)));
      chk({tag, "_data"}, 32'(cpu_data_m), 32'(exp));
    end
    mem_valid = 1'b0;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    sel = 0;
    rst = 1'b0;
    cpu_req = 1'b1;
    cpu_addr = 16'h1234;
    flush = 1'b0;
    mem_valid = 1'b0;
    mem_data = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall_m), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd_m), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr_m), 32'd0);
    chk("rst_cpu_data", 32'(cpu_data_m), 32'd0);
    chk("rst_state", 32'(dbg_m), 32'(S_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;

    // Cold miss then hits in the same block
    access("cold_miss",  16'h1234, 16'hA000, 1, 1, -1, 0, -1);
    access("cold_hit",   16'h1236, 16'hA000, 0, 1, -1, 0, -1);

    // Two-way conflict in set 1
    access("conf_a",     16'h0010, 16'hB000, 1, 1, -1, 0, -1);
    access("conf_b",     16'h1010, 16'hC000, 1, 1, -1, 0, -1);
    access("conf_a_hit", 16'h0012, 16'hB000, 0, 1, -1, 0, -1);
    access("conf_b_hit", 16'h101E, 16'hC000, 0, 1, -1, 0, -1);
    access("conf_c",     16'h2010, 16'hD000, 1, 1, -1, 0, -1);
    access("conf_b_kept",16'h1010, 16'hC000, 0, 1, -1, 0, -1);
    access("conf_a_miss",16'h0010, 16'hB000, 1, 1, -1, 0, -1);
    access("conf_c_kept",16'h2010, 16'hD000, 0, 1, -1, 0, -1);
    access("conf_b_evic",16'h1010, 16'hC000, 1, 1, -1, 0, -1);

    // Gapped beats, one every third cycle
    access("gap_miss",   16'h4444, 16'h5000, 1, 3, -1, 0, -1);
    access("gap_hit",    16'h444E, 16'h5000, 0, 1, -1, 0, -1);

    // Flush during FILL: fill completes, line dropped, retry refills
    access("fl_fill",    16'h6000, 16'h6100, 2, 1, 3, 0, -1);
    access("fl_old_inv", 16'h444E, 16'h5000, 1, 1, -1, 0, -1);
    access("fl_refill",  16'h6002, 16'h6100, 0, 1, -1, 0, -1);

    // Flush in IDLE with a request in the same cycle
    access("fl_idle",    16'h6002, 16'h6100, 1, 1, -1, 1, -1);
    access("fl_idle_a",  16'h1234, 16'hA000, 1, 1, -1, 0, -1);
    access("fl_idle_hit",16'h1236, 16'hA000, 0, 1, -1, 0, -1);

    // Reset in the middle of a refill
    access("rst_mid",    16'h5550, 16'h7000, 1, 1, -1, 0, 4);
    access("rst_after",  16'h1234, 16'hA000, 1, 1, -1, 0, -1);

    // Four-way build: five blocks in set 3, then round-robin continues
    sel = 1;
    access("w4_0",       16'h0030, 16'h8000, 1, 1, -1, 0, -1);
    access("w4_1",       16'h0130, 16'h8100, 1, 1, -1, 0, -1);
    access("w4_2",       16'h0230, 16'h8200, 1, 1, -1, 0, -1);
    access("w4_3",       16'h0330, 16'h8300, 1, 1, -1, 0, -1);
    access("w4_4",       16'h0430, 16'h8400, 1, 1, -1, 0, -1);
    access("w4_hit1",    16'h0132, 16'h8100, 0, 1, -1, 0, -1);
    access("w4_hit2",    16'h0234, 16'h8200, 0, 1, -1, 0, -1);
    access("w4_hit3",    16'h0336, 16'h8300, 0, 1, -1, 0, -1);
    access("w4_hit4",    16'h0438, 16'h8400, 0, 1, -1, 0, -1);
    access("w4_evict0",  16'h0030, 16'h8000, 1, 1, -1, 0, -1);
    access("w4_keep2",   16'h0230, 16'h8200, 0, 1, -1, 0, -1);
    access("w4_evict1",  16'h0130, 16'h8100, 1, 1, -1, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
